// File: rtl/oldland_muldiv.sv
// Iterative multiply/divide unit for the Oldland execute stage.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle.
// Optional early-out for trivial operands: define OLDLAND_MULDIV_EARLY_OUT_EN.
module oldland_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       rd_sel_in,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_sel_out,
  output logic             div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, hi_sel_q, neg_a_q, neg_b_q, dz_q;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, fix_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         rd_q, rd_out_q;
  logic               done_q, div_zero_q;

  // Input decode at acceptance
  logic             in_div, in_sgn, in_neg_a, in_neg_b, in_b_zero, early, accept;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign in_div    = op[2];
  // Reserved 010 falls through as an unsigned low-word multiply
  assign in_sgn    = in_div ? op[1] : (op[1] & op[0]);
  assign in_neg_a  = in_sgn & op_a[WIDTH-1];
  assign in_neg_b  = in_sgn & op_b[WIDTH-1];
  assign abs_a     = in_neg_a ? -op_a : op_a;
  assign abs_b     = in_neg_b ? -op_b : op_b;
  assign in_b_zero = (op_b == '0);
  assign accept    = (state_q == StIdle) && start && !kill;

`ifdef OLDLAND_MULDIV_EARLY_OUT_EN
  assign early = in_div ? (in_b_zero || (op_b == WIDTH'(1)))
                        : ((op_a == '0) || in_b_zero);
`else
  assign early = 1'b0;
`endif

  // Iteration step datapath
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  // Only used when div_ge, where the true difference fits in WIDTH bits
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  // Sign fix-up and result select
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_d;
  logic               neg_res;

  assign neg_res  = neg_a_q ^ neg_b_q;
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_res ? -prod : prod;
  // Divide by zero forces all-ones quotient regardless of signs
  assign quot_fix = dz_q ? '1 : (neg_res ? -lo_q : lo_q);
  assign rem_fix  = neg_a_q ? -hi_q : hi_q;
  assign fix_d    = div_q ? (hi_sel_q ? rem_fix : quot_fix)
                          : (hi_sel_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0]);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !kill) state_d = early ? StFix : StRun;
      StRun: begin
        if (kill) state_d = StIdle;
        else if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix:  state_d = kill ? StIdle : StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand latch, iteration and fix-up registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      fix_q    <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      cnt_q    <= CNT_W'(WIDTH);
      div_q    <= in_div;
      hi_sel_q <= op[0];
      neg_a_q  <= in_neg_a;
      neg_b_q  <= in_neg_b;
      dz_q     <= in_div & in_b_zero;
      rd_q     <= rd_sel_in;
      hi_q     <= '0;
      opnd_q   <= in_div ? abs_b : abs_a;
      lo_q     <= in_div ? abs_a : abs_b;
      // Early-out loads the final datapath contents directly
      if (early && !in_div) lo_q <= '0;
      if (early && in_div && in_b_zero) begin
        hi_q <= abs_a;
        lo_q <= '1;
      end
    end else if (state_q == StRun) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (div_q) begin
        hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_q <= mul_sum[WIDTH:1];
        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end else if (state_q == StFix) begin
      fix_q <= fix_d;
    end
  end

  // Output registers: done pulse and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= (state_q == StDone) && !kill;
      if ((state_q == StDone) && !kill) begin
        result_q   <= fix_q;
        rd_out_q   <= rd_q;
        div_zero_q <= dz_q;
      end
    end
  end

  assign ready      = (state_q == StIdle);
  assign busy       = (start && ready) || !ready;
  assign done       = done_q;
  assign result     = result_q;
  assign rd_sel_out = rd_out_q;
  assign div_zero   = div_zero_q;

endmodule

// File: doc/oldland_muldiv.md
Name: oldland_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the Oldland execute stage.
- Replaces the single-cycle low-word-only multiply with a multi-cycle engine.
- Supports low/high multiply and signed/unsigned divide and remainder, at one bit per cycle.
- Execute launches an operation, stalls while busy, and writes `result` to `rd_sel_out` on `done`.

Parameters:
- WIDTH, 32: operand and result width in bits; must be >= 4.
- CNT_W, 6: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; accepted only when ready=1
- op  in  3  000 MUL (low), 001 MULHU, 011 MULHS, 100 DIVU, 101 REMU, 110 DIV, 111 REM; 010 reserved
- op_a  in  WIDTH  multiplicand / dividend
- op_b  in  WIDTH  multiplier / divisor
- rd_sel_in  in  4  destination register, carried with the operation
- kill  in  1  abort in-flight operation (branch/exception flush)
- ready  out  1  high in IDLE only
- busy  out  1  start&&ready, or state!=IDLE; drives the pipeline stall
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  operation result; held until the next done
- rd_sel_out  out  4  destination register for result; held with result
- div_zero  out  1  valid with done; set when a divide/remainder op had op_b==0

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; done=0, result=0, rd_sel_out=0, div_zero=0; counter and datapath regs cleared.
- FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE, start=1, kill=0 at edge E0:
  - Latch op, rd_sel_in, and sign flags.
  - Latch |op_a| and |op_b| (absolute values for signed ops only; unsigned ops use raw values).
  - Counter = WIDTH; go to RUN.
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - Counter decrements each cycle; when it reaches 1, move to FIX.
  - RUN occupies exactly WIDTH cycles.
- FIX:
  - Apply negation for signed ops.
  - MULHS negates the 2*WIDTH product when the operand signs differ.
  - DIV quotient is negative when the signs differ; REM remainder takes the dividend's sign.
  - Select the result; go to DONE.
- DONE: done=1 for exactly one cycle with result, rd_sel_out and div_zero; next state IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH+2; the next start can be accepted in that following IDLE cycle.
- start while not ready: ignored, no queueing.
- Reserved op 010: executes as MUL.
- Multiply results:
  - MUL returns product[WIDTH-1:0].
  - MULHU/MULHS return product[2*WIDTH-1:WIDTH].
- Divide by zero (op_b==0, divide ops): quotient = all ones; remainder = op_a unmodified; div_zero=1. Holds for signed ops too.
- Signed overflow (op_a = most-negative, op_b = -1): DIV = most-negative, REM = 0, div_zero=0.
- kill:
  - In RUN/FIX/DONE, the next state is IDLE and done is suppressed that cycle; result and rd_sel_out keep their previous values.
  - kill with start in IDLE: start is not accepted.
- rst_n asserted mid-operation: immediate return to IDLE and all outputs at reset values.

Optional Feature:
- Macro: OLDLAND_MULDIV_EARLY_OUT_EN.
- When defined:
  - At acceptance, the FSM goes straight to FIX, so done is high in the cycle after edge E0+2, if any of the following holds:
    - a multiply op has op_a==0 or op_b==0 (result 0);
    - a divide op has op_b==0 (div-by-zero result above);
    - a divide op has op_b==1 (quotient=op_a, remainder=0).
  - All other cases keep full latency.
- When not defined: every operation takes WIDTH+2 cycles to done; results are identical in both builds.

Test Plan:
- WIDTH=32, MUL op_a=0x0001_0003, op_b=0x0002_0005 -> done after 34 cycles, result=0x000B_000F, div_zero=0, rd_sel_out=rd_sel_in.
- MULHS op_a=0xFFFF_FFFE (-2), op_b=0x0000_0003 -> result=0xFFFF_FFFF; MULHU with the same operands -> result=0x0000_0002.
- DIV op_a=0xFFFF_FFF9 (-7), op_b=2 -> result=0xFFFF_FFFD (-3); REM with the same operands -> 0xFFFF_FFFF (-1); DIV op_a=0x8000_0000, op_b=0xFFFF_FFFF -> 0x8000_0000.
- DIVU op_a=0x1234, op_b=0 -> result=0xFFFF_FFFF, div_zero=1; REMU with the same operands -> result=0x1234, div_zero=1; with EARLY_OUT_EN, done 2 cycles after start.
- Start DIVU, assert kill in RUN cycle 10 -> no done pulse, ready=1 the next cycle, result unchanged; new start accepted and completes correctly.
- Hold start high during busy with changing operands -> only the first operation completes; deassert rst_n mid-RUN -> done=0, result=0 immediately, ready=1 after release.
